// File: rtl/voice_cmd_decoder_pkg.sv
// Shared constants and state encodings for the voice-command decoder.
// ASCII digits plus the parser and strobe-scheduler state types.
package voice_cmd_pkg;

    localparam logic [7:0] ASC_0 = 8'h30;
    localparam logic [7:0] ASC_1 = 8'h31;

    typedef enum logic {
        P_IDLE = 1'b0,
        P_CH   = 1'b1
    } parser_state_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_GAP  = 1'b1
    } sched_state_e;

endpackage

// File: rtl/voice_cmd_decoder_pulse_spacer.sv
// Turns changes in the latched channel state into on/off strobes, one at a
// time, with at least GAP_CYCLES cycles between consecutive strobe starts.
module pulse_spacer
    import voice_cmd_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int GAP_CYCLES = 76800
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ch_state,
    input  logic [NUM_CH-1:0] man_off,
    output logic [NUM_CH-1:0] on_pulse,
    output logic [NUM_CH-1:0] off_pulse
);

    localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int GW = $clog2(GAP_CYCLES);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 2);

    sched_state_e      state_q, state_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [NUM_CH-1:0] emitted_q, emitted_d;
    logic [NUM_CH-1:0] on_q, on_d, off_q, off_d;
    logic [NUM_CH-1:0] pending;
    logic [SW-1:0]     sel;
    logic              found;

    // A channel being manually cleared this cycle must not be picked.
    always_comb begin
        pending = (ch_state ^ emitted_q) & ~man_off;
        sel     = '0;
        found   = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel   = SW'(i);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        emitted_d = emitted_q;
        on_d      = '0;
        off_d     = '0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    if (ch_state[sel]) on_d[sel] = 1'b1;
                    else               off_d[sel] = 1'b1;
                    emitted_d[sel] = ch_state[sel];
                    gap_d          = '0;
                    state_d        = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) state_d = S_IDLE;
                else                   gap_d   = gap_q + GW'(1);
            end
            default: state_d = S_IDLE;
        endcase
        emitted_d = emitted_d & ~man_off;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            gap_q     <= '0;
            emitted_q <= '0;
            on_q      <= '0;
            off_q     <= '0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            emitted_q <= emitted_d;
            on_q      <= on_d;
            off_q     <= off_d;
        end
    end

    assign on_pulse  = on_q;
    assign off_pulse = off_q;

endmodule

// File: rtl/voice_cmd_decoder.sv
// Voice-command decoder: parses "<letter><0|1>" byte pairs, latches per-channel
// state with an automatic hold timeout, and hands state changes to the spacer.
module voice_cmd_decoder
    import voice_cmd_pkg::*;
#(
    parameter int         NUM_CH      = 4,
    parameter logic [7:0] CMD_BASE    = 8'h47,
    parameter int         GAP_CYCLES  = 76800,
    parameter int         TICK_CYCLES = 24000000,
    parameter int         HOLD_SEC    = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic [NUM_CH-1:0] man_off,
    output logic [NUM_CH-1:0] ch_state,
    output logic [NUM_CH-1:0] on_pulse,
    output logic [NUM_CH-1:0] off_pulse,
    output logic              voice_mode,
    output logic              err_pulse
);

    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int HW = (HOLD_SEC > 0) ? $clog2(HOLD_SEC + 1) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'((HOLD_SEC > 0) ? HOLD_SEC - 1 : 0);

    parser_state_e     pstate_q, pstate_d;
    logic [CW-1:0]     ch_idx_q, ch_idx_d;
    logic              err_q, err_d;
    logic              vm_q, vm_d;
    logic [NUM_CH-1:0] ch_q, ch_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [HW-1:0]     hold_q [NUM_CH];
    logic [HW-1:0]     hold_d [NUM_CH];
    logic [8:0]        offs;
    logic              is_letter, is_digit, tick, cmd_valid, cmd_val;
    logic [CW-1:0]     letter_idx;

    always_comb begin
        offs       = {1'b0, rx_data} - {1'b0, CMD_BASE};
        is_letter  = (rx_data >= CMD_BASE) && (offs < 9'(NUM_CH));
        letter_idx = offs[CW-1:0];
        is_digit   = (rx_data == ASC_0) || (rx_data == ASC_1);
    end

    always_comb begin
        pstate_d  = pstate_q;
        ch_idx_d  = ch_idx_q;
        err_d     = 1'b0;
        cmd_valid = 1'b0;
        cmd_val   = 1'b0;
        if (rx_valid) begin
            case (pstate_q)
                P_IDLE: begin
                    if (is_letter) begin
                        ch_idx_d = letter_idx;
                        pstate_d = P_CH;
                    end
                end
                P_CH: begin
                    if (is_digit) begin
                        cmd_valid = 1'b1;
                        cmd_val   = (rx_data == ASC_1);
                        pstate_d  = P_IDLE;
                    end else if (is_letter) begin
                        ch_idx_d = letter_idx;
                    end else begin
                        err_d    = 1'b1;
                        pstate_d = P_IDLE;
                    end
                end
                default: pstate_d = P_IDLE;
            endcase
        end
    end

    // Later assignments win: man_off over command over auto-off.
    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? '0 : presc_q + PW'(1);
        for (int i = 0; i < NUM_CH; i++) begin
            ch_d[i]   = ch_q[i];
            hold_d[i] = hold_q[i];
            if (HOLD_SEC > 0 && tick && ch_q[i]) begin
                if (hold_q[i] == HOLD_LAST) begin
                    ch_d[i]   = 1'b0;
                    hold_d[i] = '0;
                end else begin
                    hold_d[i] = hold_q[i] + HW'(1);
                end
            end
            if (cmd_valid && ch_idx_q == CW'(i)) begin
                ch_d[i]   = cmd_val;
                hold_d[i] = '0;
            end
            if (man_off[i]) begin
                ch_d[i]   = 1'b0;
                hold_d[i] = '0;
            end
        end
        if (man_off != '0)  vm_d = 1'b0;
        else if (cmd_valid) vm_d = 1'b1;
        else                vm_d = vm_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pstate_q <= P_IDLE;
            ch_idx_q <= '0;
            err_q    <= 1'b0;
            vm_q     <= 1'b0;
            ch_q     <= '0;
            presc_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) hold_q[i] <= '0;
        end else begin
            pstate_q <= pstate_d;
            ch_idx_q <= ch_idx_d;
            err_q    <= err_d;
            vm_q     <= vm_d;
            ch_q     <= ch_d;
            presc_q  <= presc_d;
            for (int i = 0; i < NUM_CH; i++) hold_q[i] <= hold_d[i];
        end
    end

    assign ch_state   = ch_q;
    assign voice_mode = vm_q;
    assign err_pulse  = err_q;

    pulse_spacer #(
        .NUM_CH     (NUM_CH),
        .GAP_CYCLES (GAP_CYCLES)
    ) u_spacer (
        .clk       (clk),
        .rst_n     (rst_n),
        .ch_state  (ch_q),
        .man_off   (man_off),
        .on_pulse  (on_pulse),
        .off_pulse (off_pulse)
    );

endmodule

// File: tb/tb_voice_cmd_decoder.sv
// Directed and randomized checks of voice_cmd_decoder with a small command
// model, a strobe monitor and an expected-order queue.
module tb_voice_cmd_decoder;

    localparam int GAP = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [3:0] man_off = 4'b0000;
    logic [3:0] ch_state, on_pulse, off_pulse;
    logic       voice_mode, err_pulse;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ev_cyc[$];
    int ev_idx[$];
    bit ev_on[$];
    logic [3:0] exp_q[$];
    int last_cyc = 0;
    bit last_valid = 1'b0;

    voice_cmd_decoder #(
        .NUM_CH      (4),
        .CMD_BASE    (8'h47),
        .GAP_CYCLES  (GAP),
        .TICK_CYCLES (16),
        .HOLD_SEC    (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .man_off    (man_off),
        .ch_state   (ch_state),
        .on_pulse   (on_pulse),
        .off_pulse  (off_pulse),
        .voice_mode (voice_mode),
        .err_pulse  (err_pulse)
    );

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // strobe monitor: one-hot, spacing, and event log
    always @(negedge clk) begin
        if (!rst_n) begin
            last_valid = 1'b0;
        end else if ((on_pulse | off_pulse) != 4'b0000) begin
            chk("strobe_onehot", $countones({on_pulse, off_pulse}), 1);
            if (last_valid) chk("strobe_spacing", (cyc - last_cyc) >= GAP, 1);
            last_valid = 1'b1;
            last_cyc   = cyc;
            for (int i = 0; i < 4; i++) begin
                if (on_pulse[i] || off_pulse[i]) begin
                    ev_cyc.push_back(cyc);
                    ev_idx.push_back(i);
                    ev_on.push_back(on_pulse[i]);
                end
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic clear_events();
        ev_cyc.delete();
        ev_idx.delete();
        ev_on.delete();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        man_off  = 4'b0000;
        step();
        step();
        rst_n = 1'b1;
        clear_events();
    endtask

    function automatic int count_ev(input int idx, input bit on);
        int n = 0;
        for (int i = 0; i < ev_idx.size(); i++)
            if (ev_idx[i] == idx && ev_on[i] == on) n++;
        return n;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ch_state"}, ch_state, 4'b0000);
        chk({tag, "_on_pulse"}, on_pulse, 4'b0000);
        chk({tag, "_off_pulse"}, off_pulse, 4'b0000);
        chk({tag, "_voice_mode"}, voice_mode, 1'b0);
        chk({tag, "_err_pulse"}, err_pulse, 1'b0);
    endtask

    initial begin
        int d;
        int t_clr;
        int prev;
        int r;
        logic [7:0] b;
        logic [3:0] m_ch;
        logic m_vm;
        logic m_err;
        logic [3:0] got;

        // reset state
        rst_n = 1'b0;
        step();
        step();
        chk_all_zero("reset");
        rst_n = 1'b1;
        clear_events();

        // basic on command
        do_reset();
        send("H");
        send("1");
        chk("h1_ch_state", ch_state, 4'b0010);
        chk("h1_voice_mode", voice_mode, 1'b1);
        step();
        chk("h1_on_pulse", on_pulse, 4'b0010);
        chk("h1_off_pulse", off_pulse, 4'b0000);

        // back-to-back commands, serialized lowest index first
        do_reset();
        send("G");
        send("1");
        d = cyc;
        send("J");
        send("1");
        send("I");
        send("1");
        repeat (20) step();
        exp_q.push_back(4'd0);
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd3);
        chk("order_count", ev_idx.size(), 3);
        if (ev_idx.size() >= 3) begin
            chk("order_first_time", ev_cyc[0], d + 1);
            chk("order_gap01", ev_cyc[1] - ev_cyc[0], GAP);
            chk("order_gap12", ev_cyc[2] - ev_cyc[1], GAP);
            for (int i = 0; i < 3; i++) begin
                got = exp_q.pop_front();
                chk("order_idx", ev_idx[i], got);
                chk("order_is_on", ev_on[i], 1'b1);
            end
        end

        // hold timeout
        do_reset();
        send("G");
        send("1");
        d = cyc;
        t_clr = -1;
        for (int k = 0; k < 60 && t_clr < 0; k++) begin
            step();
            if (ch_state[0] == 1'b0) t_clr = cyc;
        end
        chk("auto_off_seen", t_clr >= 0, 1);
        chk("auto_off_window", (t_clr - d >= 33) && (t_clr - d <= 48), 1);
        repeat (20) step();
        chk("auto_off_strobes", count_ev(0, 1'b0), 1);
        chk("auto_on_strobes", count_ev(0, 1'b1), 1);

        // toggle before service, ignored bytes, malformed command
        do_reset();
        send("H");
        send("1");
        send("G");
        send("1");
        send("G");
        send("0");
        repeat (14) step();
        chk("toggle_no_strobe", count_ev(0, 1'b1) + count_ev(0, 1'b0), 0);
        chk("toggle_ch1_strobe", count_ev(1, 1'b1), 1);
        chk("toggle_state", ch_state, 4'b0010);
        send("X");
        chk("ignore_x_state", ch_state, 4'b0010);
        chk("ignore_x_err", err_pulse, 1'b0);
        send("Z");
        send("1");
        chk("ignore_z1_state", ch_state, 4'b0010);
        chk("ignore_z1_err", err_pulse, 1'b0);
        send("G");
        chk("g5_err_before", err_pulse, 1'b0);
        send("5");
        chk("g5_err", err_pulse, 1'b1);
        chk("g5_state", ch_state, 4'b0010);
        step();
        chk("g5_err_once", err_pulse, 1'b0);

        // manual override
        do_reset();
        send("H");
        send("1");
        man_off = 4'b0010;
        step();
        man_off = 4'b0000;
        chk("man_state", ch_state, 4'b0000);
        chk("man_voice_mode", voice_mode, 1'b0);
        repeat (12) step();
        chk("man_no_strobe", count_ev(1, 1'b1) + count_ev(1, 1'b0), 0);
        send("H");
        rx_data  = "1";
        rx_valid = 1'b1;
        man_off  = 4'b0010;
        step();
        rx_valid = 1'b0;
        man_off  = 4'b0000;
        chk("man_same_cycle_state", ch_state, 4'b0000);
        chk("man_same_cycle_vm", voice_mode, 1'b0);
        repeat (12) step();
        chk("man_same_cycle_no_strobe", count_ev(1, 1'b1) + count_ev(1, 1'b0), 0);

        // reset during a strobe sequence
        do_reset();
        send("G");
        send("1");
        send("H");
        send("1");
        step();
        rst_n = 1'b0;
        step();
        chk_all_zero("midrst");
        rst_n = 1'b1;
        clear_events();
        send("G");
        send("1");
        chk("post_rst_state", ch_state, 4'b0001);
        chk("post_rst_vm", voice_mode, 1'b1);
        step();
        chk("post_rst_on", on_pulse, 4'b0001);
        chk("post_rst_off", off_pulse, 4'b0000);
        repeat (12) step();
        chk("post_rst_no_ch1", count_ev(1, 1'b1), 0);

        // randomized bursts against the command model
        for (int burst = 0; burst < 8; burst++) begin
            do_reset();
            prev = -1;
            m_ch = 4'b0000;
            m_vm = 1'b0;
            for (int k = 0; k < 12; k++) begin
                r = $urandom_range(0, 10);
                case (r)
                    0, 1, 2, 3: b = 8'h47 + 8'(r);
                    4:          b = "0";
                    5, 6:       b = "1";
                    7:          b = "5";
                    8:          b = "X";
                    9:          b = "F";
                    default:    b = "K";
                endcase
                m_err = 1'b0;
                if (b >= 8'h47 && b <= 8'h4A) begin
                    prev = int'(b) - 8'h47;
                end else if (prev >= 0) begin
                    if (b == "0" || b == "1") begin
                        m_ch[prev] = (b == "1");
                        m_vm = 1'b1;
                    end else begin
                        m_err = 1'b1;
                    end
                    prev = -1;
                end
                send(b);
                chk("rnd_ch_state", ch_state, m_ch);
                chk("rnd_err", err_pulse, m_err);
                chk("rnd_vm", voice_mode, m_vm);
                if ($urandom_range(0, 1) == 1) begin
                    step();
                    chk("rnd_err_idle", err_pulse, 1'b0);
                end
            end
        end

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
